// File: rtl/key_debounce_if.sv
// Key board signal bundle: raw active-low buttons in, conditioned levels and pulses out.
interface key_debounce_if #(
  parameter int KEY_W = 4
);
  logic [KEY_W-1:0] key_in;
  logic [KEY_W-1:0] key_state;
  logic [KEY_W-1:0] key_press;
  logic [KEY_W-1:0] key_release;
  logic [KEY_W-1:0] key_long;

  modport master (
    output key_in,
    input  key_state, key_press, key_release, key_long
  );

  modport slave (
    input  key_in,
    output key_state, key_press, key_release, key_long
  );
endinterface

// File: rtl/key_debounce.sv
// Multi-key conditioner: 2-flop sync, per-key debounce FSM, press/release/long/repeat pulses.
module key_debounce #(
  parameter int KEY_W      = 4,
  parameter int DEB_CNT    = 20,
  parameter int LONG_CNT   = 100,
  parameter int REPEAT_CNT = 25
) (
  input  logic          clk,
  input  logic          rst,
  key_debounce_if.slave bus
);

  localparam int DW = $clog2(DEB_CNT);
  localparam int HW = $clog2(LONG_CNT);
  localparam int RW = $clog2(REPEAT_CNT);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CNT - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CNT - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CNT - 1);

  typedef enum logic [1:0] {IDLE, PDEB, HELD, RDEB} state_t;

  logic [KEY_W-1:0] sync1;
  logic [KEY_W-1:0] key_sync;
  logic [KEY_W-1:0] pressed;
  logic [KEY_W-1:0] press_pulse;
  logic [KEY_W-1:0] release_pulse;
  logic [KEY_W-1:0] long_pulse;

  state_t          fsm       [KEY_W];
  logic [DW-1:0]   deb_cnt   [KEY_W];
  logic [HW-1:0]   hold_cnt  [KEY_W];
  logic [RW-1:0]   rep_cnt   [KEY_W];
  logic            long_done [KEY_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1         <= '1;
      key_sync      <= '1;
      pressed       <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      long_pulse    <= '0;
      for (int unsigned k = 0; k < KEY_W; k++) begin
        fsm[k]       <= IDLE;
        deb_cnt[k]   <= '0;
        hold_cnt[k]  <= '0;
        rep_cnt[k]   <= '0;
        long_done[k] <= 1'b0;
      end
    end else begin
      sync1         <= bus.key_in;
      key_sync      <= sync1;
      press_pulse   <= '0;
      release_pulse <= '0;
      long_pulse    <= '0;
      for (int unsigned k = 0; k < KEY_W; k++) begin
        case (fsm[k])
          IDLE: begin
            if (!key_sync[k]) begin
              fsm[k]     <= PDEB;
              deb_cnt[k] <= '0;
            end
          end
          PDEB: begin
            if (key_sync[k]) begin
              fsm[k] <= IDLE;
            end else if (deb_cnt[k] == DEB_LAST) begin
              fsm[k]         <= HELD;
              press_pulse[k] <= 1'b1;
              pressed[k]     <= 1'b1;
              hold_cnt[k]    <= '0;
              rep_cnt[k]     <= '0;
              long_done[k]   <= 1'b0;
            end else begin
              deb_cnt[k] <= deb_cnt[k] + 1'b1;
            end
          end
          HELD: begin
            // Leaving for RDEB leaves hold/repeat counters untouched so a
            // release glitch only delays, never restarts, the long timing.
            if (key_sync[k]) begin
              fsm[k]     <= RDEB;
              deb_cnt[k] <= '0;
            end else if (!long_done[k]) begin
              if (hold_cnt[k] == HOLD_LAST) begin
                long_pulse[k] <= 1'b1;
                long_done[k]  <= 1'b1;
                rep_cnt[k]    <= '0;
              end else begin
                hold_cnt[k] <= hold_cnt[k] + 1'b1;
              end
            end else if (rep_cnt[k] == REP_LAST) begin
              long_pulse[k] <= 1'b1;
              rep_cnt[k]    <= '0;
            end else begin
              rep_cnt[k] <= rep_cnt[k] + 1'b1;
            end
          end
          RDEB: begin
            if (!key_sync[k]) begin
              fsm[k] <= HELD;
            end else if (deb_cnt[k] == DEB_LAST) begin
              fsm[k]           <= IDLE;
              release_pulse[k] <= 1'b1;
              pressed[k]       <= 1'b0;
              hold_cnt[k]      <= '0;
              rep_cnt[k]       <= '0;
              long_done[k]     <= 1'b0;
            end else begin
              deb_cnt[k] <= deb_cnt[k] + 1'b1;
            end
          end
          default: fsm[k] <= IDLE;
        endcase
      end
    end
  end

  assign bus.key_state   = pressed;
  assign bus.key_press   = press_pulse;
  assign bus.key_release = release_pulse;
  assign bus.key_long    = long_pulse;

endmodule

// File: doc/key_debounce.md
# key_debounce

Multi-key input conditioner for the key/LCD/segment board. It is the input-side counterpart to the LED pattern drivers. It synchronises raw active-low push-button lines, debounces each key with its own state machine, and emits clean press, release, long-press and auto-repeat pulses to downstream display and control logic. Each key is fully independent.

## Interface

Parameters:
- KEY_W, 4: number of keys.
- DEB_CNT, 20: cycles the synchronised level must be stable before a press or release is accepted. Minimum 2.
- LONG_CNT, 100: cycles in HELD before key_long fires. Minimum 2.
- REPEAT_CNT, 25: period in cycles of key_long repeats after the first one. Minimum 2.

Ports:
- clk, input, 1: single system clock, 50 MHz on board.
- rst, input, 1: synchronous, active-high reset.
- key_in, input, KEY_W: raw asynchronous buttons. 0 = pressed.
- key_state, output, KEY_W: debounced level. 1 = pressed.
- key_press, output, KEY_W: one-cycle pulse when a press is accepted.
- key_release, output, KEY_W: one-cycle pulse when a release is accepted.
- key_long, output, KEY_W: one-cycle pulse for the first long-press event and for each repeat.

## Operation

- **Synchroniser:** two flops per key, reset to all-ones (released). key_sync is the second-flop output.
- **Per-key FSM:** states IDLE, PDEB, HELD, RDEB. Reset state is IDLE.
- **Per-key counters:**
  - deb_cnt: width clog2(DEB_CNT).
  - hold_cnt: width clog2(LONG_CNT).
  - rep_cnt: width clog2(REPEAT_CNT).
  - long_done flag.
- **IDLE**
  - key_sync=0: go to PDEB, deb_cnt←0.
- **PDEB**
  - key_sync=1: go back to IDLE. This is a bounce; no pulse is emitted.
  - Else if deb_cnt==DEB_CNT-1: go to HELD, pulse key_press, key_state←1, hold_cnt←0, rep_cnt←0, long_done←0.
  - Else: deb_cnt+1.
- **HELD**
  - key_sync=1: go to RDEB, deb_cnt←0. Hold and repeat counters freeze.
  - Else, before the first long event (long_done=0):
    - hold_cnt==LONG_CNT-1: pulse key_long, long_done←1, rep_cnt←0.
    - Otherwise: hold_cnt+1.
  - Else, after the first long event (long_done=1):
    - rep_cnt==REPEAT_CNT-1: pulse key_long, rep_cnt←0.
    - Otherwise: rep_cnt+1.
- **RDEB**
  - key_sync=0: return to HELD. Frozen counters resume; no pulse is emitted.
  - Else if deb_cnt==DEB_CNT-1: go to IDLE, pulse key_release, key_state←0, clear hold_cnt, rep_cnt and long_done.
  - Else: deb_cnt+1.
- All outputs are registered.
- Only one pulse type can fire per key per cycle. key_press and key_release never coincide, and key_long never fires on the key_press or key_release cycle.
- Keys never interact. Simultaneous presses on several keys produce simultaneous pulses on those bits.

## Timing

- **Reset values:**
  - key_state, key_press, key_release and key_long are 0.
  - Synchroniser flops are 1.
  - FSM is IDLE and all counters are 0.
- rst asserted mid-operation takes effect at the next edge, whatever the state. No release pulse is generated for a key held during reset.
- Edge e0 is the edge that first samples key_in low. With key_in held low:
  - key_press and key_state rise at edge e0+DEB_CNT+2.
  - With the defaults, that is edge 22.
- First key_long fires LONG_CNT edges after the key_press edge.
- Subsequent key_long pulses fire every REPEAT_CNT edges for as long as the key stays in HELD.
- Release has the same latency as press: key_release asserts, and key_state falls, DEB_CNT+2 edges after the first sampled high.
- A glitch shorter than DEB_CNT cycles after synchronisation never changes key_state.
- Counter compares are exact equality, so counters never wrap.

## Test plan

1. **Reset:** hold rst for 3 cycles with key_in=4'b0000 → all outputs 0 during reset. After release, key_press[3:0] fires at edge 22 after the first sample.
2. **Clean press:** key_in[0] goes low at e0 (defaults) → key_press[0] at e22, key_state[0]=1 from e22. key_in[0] high at e60 → key_release[0] at e82, key_state[0]=0.
3. **Bounce:** key_in[1] toggles low 5 cycles, high 3 cycles, low 5 cycles, then high → no key_press[1], key_state[1] stays 0.
4. **Long press with repeats:** key_in[2] low for 300 cycles → key_press[2] at e22, key_long[2] at e122, e147, e172, … until release is accepted. key_release[2] fires 22 edges after key_in[2] goes high.
5. **Release glitch in HELD:** key_in[3] goes high for 10 cycles at hold_cnt=50 → no key_release[3]. The first key_long[3] is delayed by the frozen RDEB time.
6. **Simultaneous keys and reset mid-hold:** key_in[0] and key_in[2] pressed together → identical press pulses on both bits. Assert rst while both are in HELD → outputs 0 next edge, no release pulse.
